// File: rtl/multi_grant_rotating_priority_arbiter.sv
// Rotating-priority arbiter issuing up to NUM_GRANT warp requests per cycle,
// with registered grants held under backpressure and per-warp starvation override.
module multi_grant_rotating_priority_arbiter #(
    parameter int NUM_REQ      = 8,
    parameter int NUM_GRANT    = 2,
    parameter int STARVE_LIMIT = 15,
    parameter int PTR_W        = $clog2(NUM_REQ),
    parameter int CNT_W        = $clog2(NUM_GRANT + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             stall_simt,
    input  logic [NUM_REQ-1:0]             stall_ibuf,
    input  logic                           gnt_ready,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_GRANT*NUM_REQ-1:0]   gnt_raw,
    output logic                           gnt_valid,
    output logic [CNT_W-1:0]               gnt_count,
    output logic [PTR_W-1:0]               ptr
);

    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    logic [NUM_REQ-1:0]           eligible_s;
    logic                         load_s;
    logic                         force_hit_s;
    logic [NUM_REQ-1:0]           force_oh_s;
    logic [NUM_GRANT*NUM_REQ-1:0] sel_raw_s;
    logic [NUM_REQ-1:0]           sel_gnt_s;
    logic [CNT_W-1:0]             sel_cnt_s;
    logic [PTR_W-1:0]             sel_ptr_s;

    logic [NUM_REQ-1:0]           gnt_r;
    logic [NUM_GRANT*NUM_REQ-1:0] gnt_raw_r;
    logic                         gnt_valid_r;
    logic [CNT_W-1:0]             gnt_count_r;
    logic [PTR_W-1:0]             ptr_r;
    logic [AGE_W-1:0]             age_r [NUM_REQ];

    assign eligible_s = req & ~stall_simt & ~stall_ibuf;
    assign load_s     = ~gnt_valid_r | gnt_ready;

    // Slot selection: optional forced requester in slot 0, then circular scan from ptr.
    always_comb begin
        int fill;
        int idx;
        fill        = 0;
        idx         = 0;
        force_hit_s = 1'b0;
        force_oh_s  = '0;
        sel_raw_s   = '0;
        sel_gnt_s   = '0;
        sel_ptr_s   = ptr_r;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!force_hit_s && eligible_s[i] && (age_r[i] == AGE_W'(STARVE_LIMIT))) begin
                force_hit_s   = 1'b1;
                force_oh_s[i] = 1'b1;
                sel_raw_s[i]  = 1'b1;
                sel_ptr_s     = PTR_W'((i == NUM_REQ - 1) ? 0 : i + 1);
                fill          = 1;
            end else begin
                fill = fill;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = int'(ptr_r) + j;
            idx = (idx < NUM_REQ) ? idx : idx - NUM_REQ;
            if (eligible_s[idx] && !force_oh_s[idx] && (fill < NUM_GRANT)) begin
                sel_raw_s[fill*NUM_REQ + idx] = 1'b1;
                sel_ptr_s = PTR_W'((idx == NUM_REQ - 1) ? 0 : idx + 1);
                fill      = fill + 1;
            end else begin
                fill = fill;
            end
        end
        for (int k = 0; k < NUM_GRANT; k++) begin
            sel_gnt_s = sel_gnt_s | sel_raw_s[k*NUM_REQ +: NUM_REQ];
        end
        sel_cnt_s = CNT_W'(fill);
    end

    // Grant registers, rotation pointer and age counters; frozen while a grant is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_r       <= '0;
            gnt_raw_r   <= '0;
            gnt_valid_r <= 1'b0;
            gnt_count_r <= '0;
            ptr_r       <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                age_r[i] <= '0;
            end
        end else if (load_s) begin
            gnt_r       <= sel_gnt_s;
            gnt_raw_r   <= sel_raw_s;
            gnt_valid_r <= |eligible_s;
            gnt_count_r <= sel_cnt_s;
            ptr_r       <= sel_ptr_s;
            // Stalled warps that still request keep aging.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (sel_gnt_s[i] || !req[i]) begin
                    age_r[i] <= '0;
                end else if (age_r[i] != AGE_W'(STARVE_LIMIT)) begin
                    age_r[i] <= age_r[i] + 1'b1;
                end
            end
        end
    end

    assign gnt       = gnt_r;
    assign gnt_raw   = gnt_raw_r;
    assign gnt_valid = gnt_valid_r;
    assign gnt_count = gnt_count_r;
    assign ptr       = ptr_r;

endmodule

// File: tb/tb_multi_grant_rotating_priority_arbiter.sv
// Directed bench: 8-req/2-grant arbiter plus an 8-req/1-grant instance with a short starvation limit.
module tb_multi_grant_rotating_priority_arbiter;

    logic        clk_s = 1'b0;
    logic        rst_s;
    logic [7:0]  req_s, stall_simt_s, stall_ibuf_s;
    logic        gnt_ready_s;
    logic [7:0]  gnt_s;
    logic [15:0] gnt_raw_s;
    logic        gnt_valid_s;
    logic [1:0]  gnt_count_s;
    logic [2:0]  ptr_s;

    logic        rst_b_s;
    logic [7:0]  req_b_s, stall_simt_b_s, stall_ibuf_b_s;
    logic        gnt_ready_b_s;
    logic [7:0]  gnt_b_s;
    logic [7:0]  gnt_raw_b_s;
    logic        gnt_valid_b_s;
    logic [0:0]  gnt_count_b_s;
    logic [2:0]  ptr_b_s;

    int checks_r = 0;
    int errors_r = 0;

    always #5 clk_s = ~clk_s;

    multi_grant_rotating_priority_arbiter #(
        .NUM_REQ(8), .NUM_GRANT(2), .STARVE_LIMIT(15)
    ) dut_a (
        .clk(clk_s), .rst(rst_s), .req(req_s), .stall_simt(stall_simt_s),
        .stall_ibuf(stall_ibuf_s), .gnt_ready(gnt_ready_s), .gnt(gnt_s),
        .gnt_raw(gnt_raw_s), .gnt_valid(gnt_valid_s), .gnt_count(gnt_count_s),
        .ptr(ptr_s)
    );

    multi_grant_rotating_priority_arbiter #(
        .NUM_REQ(8), .NUM_GRANT(1), .STARVE_LIMIT(2)
    ) dut_b (
        .clk(clk_s), .rst(rst_b_s), .req(req_b_s), .stall_simt(stall_simt_b_s),
        .stall_ibuf(stall_ibuf_b_s), .gnt_ready(gnt_ready_b_s), .gnt(gnt_b_s),
        .gnt_raw(gnt_raw_b_s), .gnt_valid(gnt_valid_b_s), .gnt_count(gnt_count_b_s),
        .ptr(ptr_b_s)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [7:0] g, input logic v,
                           input logic [1:0] c, input logic [2:0] p);
        check_value({tag, ".gnt"}, 32'(gnt_s), 32'(g));
        check_value({tag, ".valid"}, 32'(gnt_valid_s), 32'(v));
        check_value({tag, ".count"}, 32'(gnt_count_s), 32'(c));
        check_value({tag, ".ptr"}, 32'(ptr_s), 32'(p));
        check_value({tag, ".union"}, 32'(gnt_raw_s[7:0] | gnt_raw_s[15:8]), 32'(g));
        check_value({tag, ".excl"}, 32'(gnt_raw_s[7:0] & gnt_raw_s[15:8]), 32'h0);
    endtask

    task automatic check_b(input string tag, input logic [7:0] g, input logic [2:0] p);
        check_value({tag, ".gnt"}, 32'(gnt_b_s), 32'(g));
        check_value({tag, ".raw"}, 32'(gnt_raw_b_s), 32'(g));
        check_value({tag, ".count"}, 32'(gnt_count_b_s), (g != 8'h00) ? 32'h1 : 32'h0);
        check_value({tag, ".ptr"}, 32'(ptr_b_s), 32'(p));
    endtask

    logic [7:0] t1_gnt [5] = '{8'h03, 8'h0C, 8'h30, 8'hC0, 8'h03};
    logic [2:0] t1_ptr [5] = '{3'd2, 3'd4, 3'd6, 3'd0, 3'd2};
    logic [7:0] t2_gnt [3] = '{8'h05, 8'h50, 8'h05};
    logic [15:0] t2_raw [3] = '{16'h0401, 16'h4010, 16'h0401};
    logic [2:0] t2_ptr [3] = '{3'd3, 3'd7, 3'd3};
    logic [7:0] t4_req [3] = '{8'hF0, 8'h0F, 8'hF0};
    logic [7:0] t5_gnt [3] = '{8'h08, 8'h40, 8'h08};
    logic [2:0] t5_ptr [3] = '{3'd4, 3'd7, 3'd4};

    initial begin
        rst_s = 1'b1; req_s = 8'h00; stall_simt_s = 8'h00; stall_ibuf_s = 8'h00; gnt_ready_s = 1'b1;
        rst_b_s = 1'b1; req_b_s = 8'h00; stall_simt_b_s = 8'h00; stall_ibuf_b_s = 8'h00;
        gnt_ready_b_s = 1'b1;
        tick();
        tick();
        check_a("reset", 8'h00, 1'b0, 2'd0, 3'd0);
        check_value("reset.raw", 32'(gnt_raw_s), 32'h0);

        // Full request set rotates two grants at a time.
        rst_s = 1'b0; req_s = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_a($sformatf("t1_%0d", i), t1_gnt[i], 1'b1, 2'd2, t1_ptr[i]);
        end

        // Sparse requests, including wrap of the scan from 7 to 0.
        rst_s = 1'b1; tick();
        rst_s = 1'b0; req_s = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_a($sformatf("t2_%0d", i), t2_gnt[i], 1'b1, 2'd2, t2_ptr[i]);
            check_value($sformatf("t2_%0d.raw", i), 32'(gnt_raw_s), 32'(t2_raw[i]));
        end

        // Stall masking, single grant, and empty load.
        req_s = 8'hFF; stall_simt_s = 8'h0F; stall_ibuf_s = 8'h30;
        tick();
        check_a("t3_stall", 8'hC0, 1'b1, 2'd2, 3'd0);
        req_s = 8'h08; stall_simt_s = 8'h00; stall_ibuf_s = 8'h00;
        tick();
        check_a("t3_one", 8'h08, 1'b1, 2'd1, 3'd4);
        check_value("t3_one.raw", 32'(gnt_raw_s), 32'h0008);
        req_s = 8'h00;
        tick();
        check_a("t3_none", 8'h00, 1'b0, 2'd0, 3'd4);

        // Backpressure holds the grant while requests toggle.
        rst_s = 1'b1; tick();
        rst_s = 1'b0; req_s = 8'hFF;
        tick();
        check_a("t4_load", 8'h03, 1'b1, 2'd2, 3'd2);
        gnt_ready_s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_s = t4_req[i];
            tick();
            check_a($sformatf("t4_hold%0d", i), 8'h03, 1'b1, 2'd2, 3'd2);
        end
        gnt_ready_s = 1'b1; req_s = 8'h0F;
        tick();
        check_a("t4_release", 8'h0C, 1'b1, 2'd2, 3'd4);

        // Reset during a held grant drops it; first grant after reset restarts at 0.
        gnt_ready_s = 1'b0; req_s = 8'hFF;
        tick();
        check_a("t6_hold", 8'h0C, 1'b1, 2'd2, 3'd4);
        rst_s = 1'b1;
        tick();
        check_a("t6_reset", 8'h00, 1'b0, 2'd0, 3'd0);
        check_value("t6_reset.raw", 32'(gnt_raw_s), 32'h0);
        rst_s = 1'b0;
        tick();
        check_a("t6_first", 8'h03, 1'b1, 2'd2, 3'd2);
        tick();
        check_a("t6_hold2", 8'h03, 1'b1, 2'd2, 3'd2);

        // Starvation override on the single-grant instance.
        check_b("t5_reset", 8'h00, 3'd0);
        check_value("t5_reset.valid", 32'(gnt_valid_b_s), 32'h0);
        rst_b_s = 1'b0; req_b_s = 8'h4A; stall_simt_b_s = 8'h02;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_b($sformatf("t5_%0d", i), t5_gnt[i], t5_ptr[i]);
        end
        stall_simt_b_s = 8'h00;
        tick();
        check_b("t5_force1", 8'h02, 3'd2);
        check_value("t5_force1.valid", 32'(gnt_valid_b_s), 32'h1);
        tick();
        check_b("t5_force6", 8'h40, 3'd7);
        tick();
        check_b("t5_force3", 8'h08, 3'd4);

        $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
        $finish;
    end

endmodule
